// File: rtl/amiq_stim_pkg.sv
// Shared types for the mux stimulus driver: the stimulus record layout and the driver FSM states.
package amiq_stim_pkg;

   localparam int DELAY_W = 8;

   typedef struct packed {
      bit                 in0;
      bit                 in1;
      bit                 sel;
      logic [DELAY_W-1:0] delay;
   } stim_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DONE
   } drv_state_e;

endpackage

// File: rtl/amiq_sync_fifo.sv
// Synchronous FIFO with one extra pointer bit so full and empty are told apart by the MSB.
module amiq_sync_fifo
   import amiq_stim_pkg::*;
#(
   parameter type T     = stim_t,
   parameter int  DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  T     din,
   output logic full,
   output logic empty,
   output T     dout
);

   localparam int AW = $clog2(DEPTH);

   T             mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   // Pushes into a full FIFO and pops from an empty one are dropped here, not by the caller.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/amiq_mux_stim_driver.sv
// Buffers stimulus records and replays each one onto the mux inputs for delay+1 clocks,
// reporting run progress, completion and FIFO underrun.
module amiq_mux_stim_driver
   import amiq_stim_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int NOF_VALUES = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        s_valid,
   output logic        s_ready,
   input  stim_t       s_stim,
   output logic        in0,
   output logic        in1,
   output logic        sel,
   output logic        busy,
   output logic        done,
   output logic        underrun,
   output logic [15:0] applied
);

   localparam logic [15:0] NOF_LAST = 16'(NOF_VALUES);

   drv_state_e         state;
   drv_state_e         state_nxt;
   stim_t              fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               clr_run;
   logic               set_ur;
   logic               dec_hold;
   logic [DELAY_W-1:0] hold_cnt;

   assign s_ready = !fifo_full;

   amiq_sync_fifo #(
      .T     (stim_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_valid),
      .pop   (pop),
      .din   (s_stim),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      clr_run   = 1'b0;
      set_ur    = 1'b0;
      dec_hold  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               clr_run   = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = HOLD;
            end else begin
               set_ur = 1'b1;
            end
         end
         HOLD: begin
            // The next record is popped on the last hold cycle so samples follow without a bubble.
            if (hold_cnt != '0) begin
               dec_hold = 1'b1;
            end else if (applied >= NOF_LAST) begin
               state_nxt = DONE;
            end else if (!fifo_empty) begin
               pop = 1'b1;
            end else begin
               set_ur    = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         in0      <= 1'b0;
         in1      <= 1'b0;
         sel      <= 1'b0;
         hold_cnt <= '0;
         applied  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == FETCH) || (state_nxt == HOLD);
         done  <= (state_nxt == DONE);
         if (pop) begin
            in0      <= fifo_dout.in0;
            in1      <= fifo_dout.in1;
            sel      <= fifo_dout.sel;
            hold_cnt <= fifo_dout.delay;
            applied  <= applied + 16'd1;
         end else if (dec_hold) begin
            hold_cnt <= hold_cnt - DELAY_W'(1);
         end
         if (clr_run) begin
            applied  <= '0;
            underrun <= 1'b0;
         end else if (set_ur) begin
            underrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_amiq_mux_stim_driver.sv
// Directed bench for amiq_mux_stim_driver: one instance with a 3-sample run, one with a 20-sample run.
module tb_amiq_mux_stim_driver;
   import amiq_stim_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic a_start = 0, a_s_valid = 0, a_s_ready, a_in0, a_in1, a_sel, a_busy, a_done, a_underrun;
   stim_t a_s_stim = '0;
   logic [15:0] a_applied;
   logic b_start = 0, b_s_valid = 0, b_s_ready, b_in0, b_in1, b_sel, b_busy, b_done, b_underrun;
   stim_t b_s_stim = '0;
   logic [15:0] b_applied;

   wire [2:0] a_out = {a_in0, a_in1, a_sel};
   wire [2:0] b_out = {b_in0, b_in1, b_sel};

   int n_checks = 0;
   int n_pass   = 0;

   amiq_mux_stim_driver #(.DEPTH(8), .NOF_VALUES(3)) u_dut_a (
      .clk(clk), .rst(rst), .start(a_start), .s_valid(a_s_valid), .s_ready(a_s_ready),
      .s_stim(a_s_stim), .in0(a_in0), .in1(a_in1), .sel(a_sel), .busy(a_busy),
      .done(a_done), .underrun(a_underrun), .applied(a_applied));

   amiq_mux_stim_driver #(.DEPTH(8), .NOF_VALUES(20)) u_dut_b (
      .clk(clk), .rst(rst), .start(b_start), .s_valid(b_s_valid), .s_ready(b_s_ready),
      .s_stim(b_s_stim), .in0(b_in0), .in1(b_in1), .sel(b_sel), .busy(b_busy),
      .done(b_done), .underrun(b_underrun), .applied(b_applied));

   function automatic stim_t mk(input bit i0, input bit i1, input bit s, input int d);
      stim_t r;
      r.in0   = i0;
      r.in1   = i1;
      r.sel   = s;
      r.delay = DELAY_W'(d);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic push_a(input stim_t r);
      bit acc = 0;
      int guard = 0;
      a_s_stim  = r;
      a_s_valid = 1'b1;
      while (!acc && guard < 50) begin
         acc = a_s_ready;
         tick();
         guard++;
      end
      a_s_valid = 1'b0;
      n_checks++;
      if (acc !== 1'b1) $display("FAIL push_a_accept: accepted=%b want 1", acc); else n_pass++;
   endtask

   task automatic push_b(input stim_t r);
      bit acc = 0;
      int guard = 0;
      b_s_stim  = r;
      b_s_valid = 1'b1;
      while (!acc && guard < 50) begin
         acc = b_s_ready;
         tick();
         guard++;
      end
      b_s_valid = 1'b0;
      n_checks++;
      if (acc !== 1'b1) $display("FAIL push_b_accept: accepted=%b want 1", acc); else n_pass++;
   endtask

   task automatic test_reset();
      tick();
      n_checks++;
      if ({a_out, b_out} !== 6'b0) $display("FAIL reset_outputs: got %b want 000000", {a_out, b_out}); else n_pass++;
      n_checks++;
      if ({a_busy, a_done, a_underrun, b_busy, b_done, b_underrun} !== 6'b0)
         $display("FAIL reset_status: got %b want 000000", {a_busy, a_done, a_underrun, b_busy, b_done, b_underrun});
      else n_pass++;
      n_checks++;
      if ({a_applied, b_applied} !== 32'd0) $display("FAIL reset_applied: got %0d/%0d want 0/0", a_applied, b_applied); else n_pass++;
      rst = 1'b0;
      tick();
      n_checks++;
      if ({a_s_ready, b_s_ready} !== 2'b11) $display("FAIL reset_s_ready: got %b want 11", {a_s_ready, b_s_ready}); else n_pass++;
   endtask

   task automatic test_basic_run();
      logic [2:0] exp_seq [6] = '{3'b100, 3'b011, 3'b011, 3'b011, 3'b110, 3'b110};
      push_a(mk(1, 0, 0, 0));
      push_a(mk(0, 1, 1, 2));
      push_a(mk(1, 1, 0, 1));
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      n_checks++;
      if (a_busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", a_busy); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (a_out !== exp_seq[i]) $display("FAIL basic_sample%0d: got %b want %b", i, a_out, exp_seq[i]); else n_pass++;
      end
      tick();
      n_checks++;
      if ({a_done, a_busy, a_underrun} !== 3'b100) $display("FAIL basic_done: done/busy/ur got %b want 100", {a_done, a_busy, a_underrun}); else n_pass++;
      n_checks++;
      if (a_applied !== 16'd3) $display("FAIL basic_applied: got %0d want 3", a_applied); else n_pass++;
      n_checks++;
      if (a_out !== 3'b110) $display("FAIL basic_last_held: got %b want 110", a_out); else n_pass++;
   endtask

   task automatic test_fifo_full();
      do_reset();
      b_s_stim  = mk(1, 0, 1, 0);
      b_s_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (b_s_ready !== 1'b1) $display("FAIL full_ready_before%0d: got %b want 1", i, b_s_ready); else n_pass++;
         tick();
      end
      n_checks++;
      if (b_s_ready !== 1'b0) $display("FAIL full_ready_after8: got %b want 0", b_s_ready); else n_pass++;
      tick();
      tick();
      n_checks++;
      if (b_s_ready !== 1'b0) $display("FAIL full_ninth_held_off: got %b want 0", b_s_ready); else n_pass++;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      n_checks++;
      if (b_s_ready !== 1'b0) $display("FAIL full_ready_in_fetch: got %b want 0", b_s_ready); else n_pass++;
      tick();
      b_s_valid = 1'b0;
      n_checks++;
      if (b_s_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b want 1", b_s_ready); else n_pass++;
   endtask

   task automatic test_underrun();
      do_reset();
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      repeat (5) tick();
      n_checks++;
      if ({b_underrun, b_busy} !== 2'b11) $display("FAIL underrun_flag: ur/busy got %b want 11", {b_underrun, b_busy}); else n_pass++;
      n_checks++;
      if (b_out !== 3'b000) $display("FAIL underrun_outputs: got %b want 000", b_out); else n_pass++;
      push_b(mk(1, 0, 1, 1));
      n_checks++;
      if (b_out !== 3'b000) $display("FAIL underrun_no_bypass: got %b want 000", b_out); else n_pass++;
      tick();
      n_checks++;
      if (b_out !== 3'b101 || b_applied !== 16'd1) $display("FAIL underrun_applied0: got %b/%0d want 101/1", b_out, b_applied); else n_pass++;
      tick();
      n_checks++;
      if (b_out !== 3'b101) $display("FAIL underrun_hold1: got %b want 101", b_out); else n_pass++;
      n_checks++;
      if (b_underrun !== 1'b1) $display("FAIL underrun_sticky: got %b want 1", b_underrun); else n_pass++;
   endtask

   task automatic test_mid_run_reset();
      int guard = 0;
      do_reset();
      for (int i = 0; i < 8; i++) push_b(mk(1, 1, 1, 1));
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      while (b_applied !== 16'd7 && guard < 100) begin
         tick();
         guard++;
      end
      n_checks++;
      if (b_applied !== 16'd7 || b_busy !== 1'b1 || b_out !== 3'b111)
         $display("FAIL midrst_reach7: applied/busy/out got %0d/%b/%b want 7/1/111", b_applied, b_busy, b_out);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (b_out !== 3'b000 || b_busy !== 1'b0 || b_applied !== 16'd0)
         $display("FAIL midrst_immediate: out/busy/applied got %b/%b/%0d want 000/0/0", b_out, b_busy, b_applied);
      else n_pass++;
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (b_s_ready !== 1'b1) $display("FAIL midrst_s_ready: got %b want 1", b_s_ready); else n_pass++;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      tick();
      n_checks++;
      if (b_underrun !== 1'b1) $display("FAIL midrst_fifo_flushed: underrun got %b want 1", b_underrun); else n_pass++;
   endtask

   task automatic test_stream();
      stim_t recs [20];
      do_reset();
      for (int i = 0; i < 20; i++)
         recs[i] = mk(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      int'($urandom_range(3, 0)));
      for (int i = 0; i < 8; i++) push_b(recs[i]);
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      fork
         begin
            for (int i = 8; i < 20; i++) push_b(recs[i]);
         end
         begin
            for (int k = 0; k < 20; k++) begin
               for (int j = 0; j <= int'(recs[k].delay); j++) begin
                  logic exp_mux;
                  logic got_mux;
                  tick();
                  exp_mux = recs[k].sel ? recs[k].in1 : recs[k].in0;
                  got_mux = b_sel ? b_in1 : b_in0;
                  n_checks++;
                  if (b_out !== {recs[k].in0, recs[k].in1, recs[k].sel} || got_mux !== exp_mux)
                     $display("FAIL stream_rec%0d_cyc%0d: out=%b mux=%b want out=%b mux=%b", k, j, b_out, got_mux,
                              {recs[k].in0, recs[k].in1, recs[k].sel}, exp_mux);
                  else n_pass++;
               end
            end
            tick();
            n_checks++;
            if ({b_done, b_underrun} !== 2'b10 || b_applied !== 16'd20)
               $display("FAIL stream_done: done/ur/applied got %b/%b/%0d want 1/0/20", b_done, b_underrun, b_applied);
            else n_pass++;
         end
      join
   endtask

   task automatic test_busy_start_long_delay();
      int cnt = 0;
      int guard = 0;
      push_a(mk(0, 1, 1, 255));
      push_a(mk(1, 0, 0, 0));
      push_a(mk(0, 0, 1, 0));
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      tick();
      while (a_out === 3'b011 && guard < 400) begin
         cnt++;
         a_start = (cnt == 5);
         tick();
         guard++;
      end
      a_start = 1'b0;
      n_checks++;
      if (cnt != 256) $display("FAIL long_hold_cycles: got %0d want 256", cnt); else n_pass++;
      n_checks++;
      if (a_out !== 3'b100 || a_applied !== 16'd2)
         $display("FAIL busy_start_ignored: out/applied got %b/%0d want 100/2", a_out, a_applied);
      else n_pass++;
      tick();
      n_checks++;
      if (a_out !== 3'b001 || a_applied !== 16'd3) $display("FAIL busy_third: out/applied got %b/%0d want 001/3", a_out, a_applied); else n_pass++;
      tick();
      n_checks++;
      if ({a_done, a_busy} !== 2'b10) $display("FAIL busy_run_done: done/busy got %b want 10", {a_done, a_busy}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_fifo_full();
      test_underrun();
      test_mid_run_reset();
      test_stream();
      do_reset();
      test_busy_start_long_delay();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
